// File: rtl/alu_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Registered valid/ready ALU with zero/carry/overflow flags. Define
//            ALU_MUL_EN to build the iterative shift-add mul/mulhu unit.
// Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int c_SHW = $clog2(WIDTH);
  localparam int c_MSB = WIDTH - 1;

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b0001;
  localparam logic [3:0] c_OP_SLL  = 4'b0010;
  localparam logic [3:0] c_OP_SLT  = 4'b0011;
  localparam logic [3:0] c_OP_SLTU = 4'b0100;
  localparam logic [3:0] c_OP_XOR  = 4'b0101;
  localparam logic [3:0] c_OP_SRL  = 4'b0110;
  localparam logic [3:0] c_OP_SRA  = 4'b0111;
  localparam logic [3:0] c_OP_OR   = 4'b1000;
  localparam logic [3:0] c_OP_AND  = 4'b1001;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nx;
  logic             w_accept;
  logic             w_load_alu;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [c_SHW-1:0] w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_zero;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  assign in_ready  = rstn && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign res       = r_res;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

  assign w_shamt = B[c_SHW-1:0];
  assign w_sum   = {1'b0, A} + {1'b0, B};
  assign w_diff  = {1'b0, A} - {1'b0, B};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (ALU_operation)
      c_OP_ADD: begin
        w_res   = w_sum[c_MSB:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (A[c_MSB] == B[c_MSB]) && (w_sum[c_MSB] != A[c_MSB]);
      end
      c_OP_SUB: begin
        // The extra top bit of the difference is the unsigned borrow.
        w_res   = w_diff[c_MSB:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (A[c_MSB] != B[c_MSB]) && (w_diff[c_MSB] != A[c_MSB]);
      end
      c_OP_SLL:  w_res = A << w_shamt;
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      c_OP_XOR:  w_res = A ^ B;
      c_OP_SRL:  w_res = A >> w_shamt;
      c_OP_SRA:  w_res = $signed(A) >>> w_shamt;
      c_OP_OR:   w_res = A | B;
      c_OP_AND:  w_res = A & B;
      default:   w_res = '0;
    endcase
    w_zero = (w_res == '0);
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0]     c_OP_MUL    = 4'b1010;
  localparam logic [3:0]     c_OP_MULHU  = 4'b1011;
  localparam logic [c_SHW:0] c_MUL_STEPS = (c_SHW+1)'(WIDTH);

  logic                 w_is_mul;
  logic                 w_mul_fin;
  logic [WIDTH-1:0]     w_mul_res;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_SHW:0]       r_cnt;
  logic                 r_hi;

  assign w_is_mul   = (ALU_operation == c_OP_MUL) || (ALU_operation == c_OP_MULHU);
  assign w_load_alu = w_accept && !w_is_mul;
  // Counter runs 0..WIDTH-1 doing steps; the extra count WIDTH is the result-select cycle.
  assign w_mul_fin  = (r_state == S_MUL) && (r_cnt == c_MUL_STEPS);
  assign w_mul_res  = r_hi ? r_acc[2*WIDTH-1:WIDTH] : r_acc[c_MSB:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_hi     <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_cnt    <= '0;
      r_hi     <= ALU_operation[0];
    end else if ((r_state == S_MUL) && !w_mul_fin) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_load_alu = w_accept;
`endif

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
`ifdef ALU_MUL_EN
          w_state_nx = w_is_mul ? S_MUL : S_DONE;
`else
          w_state_nx = S_DONE;
`endif
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nx = S_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (w_mul_fin) begin
          w_state_nx = S_DONE;
        end
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_load_alu) begin
        r_res   <= w_res;
        r_zero  <= w_zero;
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
      end
`ifdef ALU_MUL_EN
      else if (w_mul_fin) begin
        r_res   <= w_mul_res;
        r_zero  <= (w_mul_res == '0);
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc (WIDTH=32).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        zero;
  logic        carry;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Base opcode sweep with A=A5A5A5A5, B=5A5A5A5A; flags are {zero, carry, overflow}.
  logic [3:0]  base_op  [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
  logic [31:0] base_res [10] = '{32'hFFFFFFFF, 32'h4B4B4B4B, 32'h94000000, 32'h00000001,
                                 32'h00000000, 32'hFFFFFFFF, 32'h00000029, 32'hFFFFFFE9,
                                 32'hFFFFFFFF, 32'h00000000};
  logic [2:0]  base_flg [10] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100,
                                 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};

  logic [31:0] ar_a   [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000,
                              32'h80000000, 32'h80000000, 32'h00000001};
  logic [31:0] ar_b   [6] = '{32'h00000001, 32'h00000001, 32'h00000001,
                              32'h00000024, 32'h00000024, 32'h0000001F};
  logic [3:0]  ar_op  [6] = '{4'h0, 4'h1, 4'h1, 4'h7, 4'h6, 4'h2};
  logic [31:0] ar_res [6] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                              32'hF8000000, 32'h08000000, 32'h80000000};
  logic [2:0]  ar_flg [6] = '{3'b001, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};

  alu_mc #(.WIDTH(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (a),
    .B            (b),
    .ALU_operation(op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .res          (res),
    .zero         (zero),
    .carry        (carry),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] ov);
    a = av; b = bv; op = ov; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 rstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, zero, carry, overflow, res} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b z=%b c=%b v=%b res=%h want all 0",
               out_valid, zero, carry, overflow, res);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_base_ops;
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = base_op[i]; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL base_ready op=%h: got %b want 1", base_op[i], in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || res !== base_res[i] || {zero, carry, overflow} !== base_flg[i]) begin
        errors++;
        $display("FAIL base_op op=%h: got valid=%b res=%h zcv=%b want valid=1 res=%h zcv=%b",
                 base_op[i], out_valid, res, {zero, carry, overflow}, base_res[i], base_flg[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL base_drain: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_arith_and_shifts;
    for (int i = 0; i < 6; i++) begin
      run_single(ar_a[i], ar_b[i], ar_op[i]);
      checks++;
      if (out_valid !== 1'b1 || res !== ar_res[i] || {zero, carry, overflow} !== ar_flg[i]) begin
        errors++;
        $display("FAIL arith_shift #%0d op=%h: got valid=%b res=%h zcv=%b want valid=1 res=%h zcv=%b",
                 i, ar_op[i], out_valid, res, {zero, carry, overflow}, ar_res[i], ar_flg[i]);
      end
    end
    tick();
  endtask

  task automatic test_illegal;
    run_single(32'h5, 32'h3, 4'hC);
    checks++;
    if (out_valid !== 1'b1 || res !== 32'h0 || {zero, carry, overflow} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_1100: got valid=%b res=%h zcv=%b want valid=1 res=0 zcv=100",
               out_valid, res, {zero, carry, overflow});
    end
`ifndef ALU_MUL_EN
    run_single(32'h10000, 32'h10000, 4'hA);
    checks++;
    if (out_valid !== 1'b1 || res !== 32'h0 || {zero, carry, overflow} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_1010: got valid=%b res=%h zcv=%b want valid=1 res=0 zcv=100",
               out_valid, res, {zero, carry, overflow});
    end
`endif
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    run_single(32'hA5A5A5A5, 32'h5A5A5A5A, 4'h0);
    a = 32'd2; b = 32'd3; op = 4'h0; in_valid = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || res !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL bp_first: got valid=%b res=%h want valid=1 res=ffffffff", out_valid, res);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || res !== 32'hFFFFFFFF || {zero, carry, overflow} !== 3'b000 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: got valid=%b res=%h zcv=%b rdy=%b want 1 ffffffff 000 0",
                 i, out_valid, res, {zero, carry, overflow}, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || res !== 32'd5) begin
      errors++;
      $display("FAIL bp_next_op: got valid=%b res=%h want valid=1 res=00000005", out_valid, res);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b want 0", out_valid);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    int  cyc;
    logic bad;
    out_ready = 1'b1;
    a = 32'h00010000; b = 32'h00010000; op = 4'hA; in_valid = 1'b1;
    tick();
    op = 4'hB;
    cyc = 0; bad = 1'b0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (cyc != 33) begin
      errors++;
      $display("FAIL mul_latency: got %0d cycles want 33", cyc);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL mul_busy_ready: got in_ready=1 during MUL want 0");
    end
    checks++;
    if (res !== 32'h0 || {zero, carry, overflow} !== 3'b100) begin
      errors++;
      $display("FAIL mul_low: got res=%h zcv=%b want res=0 zcv=100", res, {zero, carry, overflow});
    end
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (cyc != 33 || res !== 32'h1 || {zero, carry, overflow} !== 3'b000) begin
      errors++;
      $display("FAIL mulhu: got cyc=%0d res=%h zcv=%b want cyc=33 res=1 zcv=000",
               cyc, res, {zero, carry, overflow});
    end
    tick();
  endtask

  task automatic test_reset_mid_op;
    int seen;
    out_ready = 1'b1;
    run_single(32'h00010000, 32'h00010003, 4'hA);
    repeat (9) tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, zero, carry, overflow, res} !== 37'h0) begin
      errors++;
      $display("FAIL reset_mid_mul: got rdy=%b valid=%b z=%b c=%b v=%b res=%h want all 0",
               in_ready, out_valid, zero, carry, overflow, res);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b want 1", in_ready);
    end
    a = 32'd2; b = 32'd3; op = 4'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || res !== 32'd5) begin
      errors++;
      $display("FAIL reset_add: got valid=%b res=%h want valid=1 res=00000005", out_valid, res);
    end
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_stale_mul: got %0d valid cycles want 0", seen);
    end
  endtask
`else
  task automatic test_reset_mid_op;
    out_ready = 1'b0;
    run_single(32'd9, 32'd9, 4'h0);
    rstn = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, zero, carry, overflow, res} !== 37'h0) begin
      errors++;
      $display("FAIL reset_mid_done: got rdy=%b valid=%b z=%b c=%b v=%b res=%h want all 0",
               in_ready, out_valid, zero, carry, overflow, res);
    end
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    #1;
    a = 32'd2; b = 32'd3; op = 4'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || res !== 32'd5) begin
      errors++;
      $display("FAIL reset_add: got valid=%b res=%h want valid=1 res=00000005", out_valid, res);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_base_ops();
    test_arith_and_shifts();
    test_illegal();
    test_backpressure();
`ifdef ALU_MUL_EN
    test_mul();
`endif
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Parametrised, registered successor to the combinational 32-bit ALU. It accepts one operation per valid/ready handshake and returns a registered result with zero, carry and overflow flags. An optional iterative shift-add multiplier takes WIDTH cycles per multiply. It sits between the decode stage and writeback of the multi-cycle CPU datapath, and can tolerate backpressure from writeback.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥8; SHW = $clog2(WIDTH) is the shift-amount width.
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation can be accepted this cycle
- A, B  in  WIDTH  operands
- ALU_operation  in  4  opcode
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes the result
- res  out  WIDTH  result
- zero  out  1  res == 0
- carry  out  1  add: carry-out; sub: borrow (A < B unsigned); otherwise 0
- overflow  out  1  signed overflow for add/sub; otherwise 0

## Operation
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 sll
  - 0011 slt (signed, res = {0…,1/0})
  - 0100 sltu
  - 0101 xor
  - 0110 srl
  - 0111 sra
  - 1000 or
  - 1001 and
  - 1010 mul (low WIDTH bits of unsigned A*B)
  - 1011 mulhu (high WIDTH bits)
  - 1100–1111 illegal: res = 0, zero = 1, carry = overflow = 0.
- Shifts use B[SHW-1:0]; the upper bits of B are ignored.
- FSM states:
  - IDLE: in_ready = 1. On accept, a single-cycle op writes res/flags and goes to DONE; mul/mulhu latches operands, clears a 2*WIDTH accumulator and goes to MUL.
  - MUL: one shift-add step per cycle, using a counter from 0 to WIDTH-1. in_ready = 0. After step WIDTH-1, selects the low or high half into res, sets flags and goes to DONE.
  - DONE: out_valid = 1. res and flags stay stable until out_ready.
    - out_ready with no new accept: go to IDLE.
    - in_ready = out_ready in DONE. An accept in the same cycle as out_ready is treated exactly as an accept from IDLE, giving back-to-back throughput of 1 op/cycle.
- Operands and opcode are sampled only on the accepting edge. Later changes on A, B or ALU_operation have no effect.
- zero is computed from the final res for every opcode, including mul.

## Timing
- Reset: asynchronous, effective immediately.
  - State goes to IDLE; res = 0, zero = 0, carry = 0, overflow = 0, out_valid = 0.
  - Counter and accumulator are cleared.
  - A multiply in flight is aborted and its result discarded.
  - in_ready = 1 once rstn is high.
- Single-cycle op: accepted at edge t; out_valid high from edge t (visible in cycle t+1). Latency is 1.
- mul/mulhu: accepted at edge t; out_valid at edge t+WIDTH+1. Latency is WIDTH+1 (33 for WIDTH=32).
- Backpressure:
  - out_valid and res stay held indefinitely while out_ready = 0.
  - No op is accepted while a result is unconsumed, except in the same cycle as out_ready.
- in_valid during MUL is ignored and no op is accepted; the source must hold in_valid and its data.
- out_ready while out_valid = 0 has no effect.

## Configuration
- ALU_MUL_EN defined: the MUL state, counter, accumulator and opcodes 1010/1011 are built as described.
- ALU_MUL_EN undefined: no MUL state or multiplier logic. 1010/1011 decode as illegal (res = 0, zero = 1, latency 1).

## Test plan
- WIDTH=32, A=A5A5A5A5, B=5A5A5A5A, step through all ten base opcodes, out_ready=1:
  - and → 00000000, zero=1; or → FFFFFFFF; xor → FFFFFFFF.
  - add → FFFFFFFF, carry=0; slt → 00000001; sltu → 00000000.
  - Each result arrives 1 cycle after accept, back-to-back.
- add 7FFFFFFF+00000001 → 80000000, overflow=1, carry=0. sub 80000000−00000001 → 7FFFFFFF, overflow=1, carry=0. sub 00000000−00000001 → FFFFFFFF, carry=1.
- Shifts:
  - sra 80000000 by B=00000024 (amount 4) → F8000000.
  - srl same operands → 08000000.
  - sll 00000001 by 0000001F → 80000000.
- ALU_MUL_EN defined:
  - mul 00010000*00010000 → 00000000, zero=1, at accept+33 cycles.
  - mulhu same operands → 00000001.
  - in_valid during MUL is not accepted (in_ready=0).
- Backpressure: out_ready held 0 for 5 cycles after a result. res, flags and out_valid must not change, in_ready=0. Raising out_ready with in_valid=1 accepts the next op in the same cycle.
- Reset:
  - Assert rstn=0 mid-multiply (cycle 10): all outputs go to 0 immediately, state is IDLE.
  - After release, an add 2+3 → 5 with latency 1.
- ALU_MUL_EN undefined: 1010 → res=0, zero=1, latency 1.
